// File: rtl/fc_weight_streamer_pkg.sv
// ============================================================================
//  Module   : fc_weight_streamer_pkg
//  Purpose  : Shared BNN constants and FSM encoding for the fc_* blocks.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package fc_weight_streamer_pkg;

    localparam int c_WORD_W_DEFAULT = 32;
    localparam int c_N_BITS_DEFAULT = 192;

    localparam int c_STATE_W = 2;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE  = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_FETCH = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_SHIFT = 2'd2;
    localparam logic [c_STATE_W-1:0] c_ST_DONE  = 2'd3;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fc_weight_streamer_piso_shift.sv
// ============================================================================
//  Module   : fc_weight_streamer_piso_shift
//  Purpose  : Parallel-in serial-out register, MSB first; load wins over shift.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fc_weight_streamer_piso_shift #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_msb
);

    logic [WIDTH-1:0] r_sreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sreg <= '0;
        end else if (i_load) begin
            r_sreg <= i_data;
        end else if (i_shift) begin
            r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
        end
    end

    assign o_msb = r_sreg[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/fc_weight_streamer.sv
// ============================================================================
//  Module   : fc_weight_streamer
//  Purpose  : Streams N_BITS packed weights into the fc_12 serial weight port.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fc_weight_streamer
    import fc_weight_streamer_pkg::*;
#(
    parameter int WORD_W = c_WORD_W_DEFAULT,
    parameter int N_BITS = c_N_BITS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              weight,
    output logic              weight_en,
    output logic              busy,
    output logic              load_done
);

    localparam int c_WB_W = cnt_width(WORD_W);
    localparam int c_TB_W = cnt_width(N_BITS);
    localparam logic [c_WB_W-1:0] c_WB_LAST = c_WB_W'(WORD_W - 1);
    localparam logic [c_TB_W-1:0] c_TB_LAST = c_TB_W'(N_BITS - 1);

    logic [c_STATE_W-1:0] r_state;
    logic [c_WB_W-1:0]    r_word_bit;
    logic [c_TB_W-1:0]    r_total_bit;
    logic                 r_weight;
    logic                 r_weight_en;
    logic                 r_busy;
    logic                 r_load_done;

    logic w_word_last;
    logic w_total_last;
    logic w_s_ready;
    logic w_xfer;
    logic w_sr_shift;
    logic w_sr_msb;

    assign w_word_last  = (r_word_bit == c_WB_LAST);
    assign w_total_last = (r_total_bit == c_TB_LAST);

    // Ready is also raised on the last bit of a word so the next word lands with no bubble.
    assign w_s_ready  = (r_state == c_ST_FETCH) ||
                        ((r_state == c_ST_SHIFT) && w_word_last && !w_total_last);
    assign w_xfer     = s_valid && w_s_ready;
    assign w_sr_shift = (r_state == c_ST_SHIFT);

    fc_weight_streamer_piso_shift #(
        .WIDTH (WORD_W)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_xfer),
        .i_shift (w_sr_shift),
        .i_data  (s_data),
        .o_msb   (w_sr_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_word_bit  <= '0;
            r_total_bit <= '0;
            r_weight    <= 1'b0;
            r_weight_en <= 1'b0;
            r_busy      <= 1'b0;
            r_load_done <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_weight_en <= 1'b0;
                    if (start) begin
                        r_state     <= c_ST_FETCH;
                        r_busy      <= 1'b1;
                        r_word_bit  <= '0;
                        r_total_bit <= '0;
                    end
                end
                c_ST_FETCH: begin
                    r_weight_en <= 1'b0;
                    if (w_xfer) begin
                        r_state    <= c_ST_SHIFT;
                        r_word_bit <= '0;
                    end
                end
                c_ST_SHIFT: begin
                    r_weight    <= w_sr_msb;
                    r_weight_en <= 1'b1;
                    if (w_total_last) begin
                        r_state <= c_ST_DONE;
                    end else begin
                        r_total_bit <= r_total_bit + c_TB_W'(1);
                        if (w_word_last) begin
                            r_word_bit <= '0;
                            if (!w_xfer) begin
                                r_state <= c_ST_FETCH;
                            end
                        end else begin
                            r_word_bit <= r_word_bit + c_WB_W'(1);
                        end
                    end
                end
                c_ST_DONE: begin
                    r_weight_en <= 1'b0;
                    r_load_done <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready   = w_s_ready;
    assign weight    = r_weight;
    assign weight_en = r_weight_en;
    assign busy      = r_busy;
    assign load_done = r_load_done;

endmodule

`default_nettype wire

// File: tb/tb_fc_weight_streamer.sv
// ============================================================================
//  Module   : tb_fc_weight_streamer
//  Purpose  : Self-checking bench for fc_weight_streamer (scoreboard of bits).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fc_weight_streamer;

    localparam int c_WORD_W  = 32;
    localparam int c_N_BITS  = 192;
    localparam int c_N_WORDS = c_N_BITS / c_WORD_W;

    typedef struct {
        logic [31:0] data;
        int          exp_ones;
        logic        exp_msb;
    } vec_t;

    vec_t tbl [c_N_WORDS];

    logic        clk;
    logic        rst;
    logic        start;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        weight;
    logic        weight_en;
    logic        busy;
    logic        load_done;

    fc_weight_streamer #(
        .WORD_W (c_WORD_W),
        .N_BITS (c_N_BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .weight    (weight),
        .weight_en (weight_en),
        .busy      (busy),
        .load_done (load_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit exp_q [$];
    int cyc = 0;
    int last_en_cyc = 0;
    int bits_seen = 0;
    int word_ones = 0;
    int done_seen = 0;
    int words_acc = 0;
    int gap_low = 0;
    int src_idx = 0;
    int pushed = 0;
    int gap_cnt = 0;
    int cur_gap = 0;
    bit restarted = 1'b0;
    bit hs_pending = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        bit e;
        cyc++;
        if (busy && !weight_en && bits_seen > 0 && bits_seen < c_N_BITS) gap_low++;
        if (weight_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_bit actual=%0d required=no_bit", weight);
            end else begin
                e = exp_q.pop_front();
                chk("weight_bit", 32'(weight), 32'(e));
            end
            if ((bits_seen % c_WORD_W) == 0 && (bits_seen / c_WORD_W) < c_N_WORDS)
                chk("word_first_bit", 32'(weight), 32'(tbl[bits_seen / c_WORD_W].exp_msb));
            word_ones += int'(weight);
            bits_seen++;
            last_en_cyc = cyc;
            if ((bits_seen % c_WORD_W) == 0 && bits_seen <= c_N_BITS) begin
                chk("word_ones", 32'(word_ones), 32'(tbl[bits_seen / c_WORD_W - 1].exp_ones));
                word_ones = 0;
            end
        end
        if (load_done) begin
            done_seen++;
            chk("done_latency", 32'(cyc - last_en_cyc), 32'd1);
            chk("bits_at_done", 32'(bits_seen), 32'(c_N_BITS));
        end
    endtask

    // Sample at negedge, then step past the rising edge and account for handshakes.
    task automatic cycle();
        @(negedge clk);
        monitor();
        hs_pending = s_valid && s_ready;
        @(posedge clk);
        #1;
        if (hs_pending) begin
            words_acc++;
            src_idx++;
            if (src_idx == 2 && cur_gap > 0) gap_cnt = c_WORD_W + cur_gap;
        end
    endtask

    task automatic drive(input int restart_at);
        if (gap_cnt > 0) begin
            s_valid = 1'b0;
            gap_cnt--;
        end else begin
            s_valid = 1'b1;
            if (src_idx < c_N_WORDS) begin
                s_data = tbl[src_idx].data;
                if (pushed == src_idx) begin
                    for (int b = c_WORD_W - 1; b >= 0; b--) exp_q.push_back(tbl[src_idx].data[b]);
                    pushed++;
                end
            end else begin
                s_data = 32'hDEAD_BEEF;
            end
        end
        start = 1'b0;
        if (restart_at >= 0 && !restarted && bits_seen >= restart_at) begin
            start     = 1'b1;
            restarted = 1'b1;
        end
    endtask

    task automatic run_load(input int gap, input int restart_at, input int rst_at, input int exp_gap_low);
        int  d0;
        bit  finished;
        exp_q.delete();
        src_idx = 0; pushed = 0; gap_cnt = 0; bits_seen = 0; word_ones = 0;
        words_acc = 0; gap_low = 0; restarted = 1'b0; cur_gap = gap;
        d0 = done_seen;
        finished = 1'b0;
        start = 1'b1;
        s_valid = 1'b0;
        cycle();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("ready_in_fetch", 32'(s_ready), 32'd1);
        for (int k = 0; k < 4000; k++) begin
            if (rst_at >= 0 && bits_seen >= rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_weight_en", 32'(weight_en), 32'd0);
                chk("rst_weight", 32'(weight), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_ready", 32'(s_ready), 32'd0);
                chk("rst_load_done", 32'(load_done), 32'd0);
                start = 1'b0;
                s_valid = 1'b0;
                cycle();
                cycle();
                rst = 1'b0;
                chk("no_done_after_rst", 32'(done_seen), 32'(d0));
                return;
            end
            drive(restart_at);
            cycle();
            if (done_seen != d0) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL load_timeout actual=no_load_done required=load_done");
        end
        // s_valid stays high with junk data: nothing more may be consumed.
        repeat (3) cycle();
        chk("words_consumed", 32'(words_acc), 32'(c_N_WORDS));
        chk("total_bits", 32'(bits_seen), 32'(c_N_BITS));
        chk("en_low_cycles", 32'(gap_low), 32'(exp_gap_low));
        chk("done_count", 32'(done_seen), 32'(d0 + 1));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("ready_after_done", 32'(s_ready), 32'd0);
    endtask

    initial begin
        tbl[0] = '{32'hFFFF_0000, 16, 1'b1};
        tbl[1] = '{32'h0000_0000,  0, 1'b0};
        tbl[2] = '{32'hAAAA_AAAA, 16, 1'b1};
        tbl[3] = '{32'h0000_0001,  1, 1'b0};
        tbl[4] = '{32'h8000_0000,  1, 1'b1};
        tbl[5] = '{32'h7FFF_FFFF, 31, 1'b0};

        rst = 1'b1;
        start = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_weight", 32'(weight), 32'd0);
        chk("reset_weight_en", 32'(weight_en), 32'd0);
        chk("reset_ready", 32'(s_ready), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_load_done", 32'(load_done), 32'd0);
        rst = 1'b0;

        // Valid data offered while idle must be left alone.
        s_valid = 1'b1;
        s_data = 32'h1234_5678;
        words_acc = 0;
        repeat (4) cycle();
        chk("idle_ready", 32'(s_ready), 32'd0);
        chk("idle_no_accept", 32'(words_acc), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        s_valid = 1'b0;

        run_load(0, -1, -1, 0);
        run_load(5, -1, -1, 6);
        run_load(0, 50, -1, 0);
        run_load(0, -1, 100, 0);
        run_load(0, -1, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fc_weight_streamer.md
FC_WEIGHT_STREAMER -- requirements
Module: fc_weight_streamer

Interface
REQ-001 Parameter WORD_W, default 32, sets the width of the packed weight word accepted on s_data.
REQ-002 Parameter N_BITS, default 192, sets the total number of weight bits per load; it SHALL be a multiple of WORD_W.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-high.
REQ-005 start  input  1  one-cycle request to begin a weight load.
REQ-006 s_valid  input  1  packed weight word available.
REQ-007 s_ready  output  1  block accepts s_data this cycle.
REQ-008 s_data  input  WORD_W  packed weights, bit WORD_W-1 sent first.
REQ-009 weight  output  1  serial binary weight bit to the fc_12 weight port.
REQ-010 weight_en  output  1  weight bit valid this cycle.
REQ-011 busy  output  1  load in progress, from start acceptance to done.
REQ-012 load_done  output  1  one-cycle pulse after the last weight bit.

Function
REQ-013 FSM states SHALL be IDLE, FETCH, SHIFT and DONE.
REQ-014 IDLE: on start=1, go to FETCH, clear the bit counters, and set busy=1 on the next cycle.
REQ-015 start while busy=1 SHALL be ignored.
REQ-016 FETCH: s_ready=1; a transfer (s_valid and s_ready) loads s_data into a WORD_W shift register and moves to SHIFT.
REQ-017 SHIFT: each cycle, drive the register MSB on weight with weight_en=1, shift left by one, and increment word_bit (0..WORD_W-1) and total_bit (0..N_BITS-1).
REQ-018 s_ready SHALL also be 1 in SHIFT when word_bit=WORD_W-1 and total_bit<N_BITS-1, so words stream with no bubble.
REQ-019 A word accepted per REQ-018 is loaded on the same edge the last bit of the current word is emitted.
REQ-020 If the current word is exhausted with no transfer, go to FETCH; weight_en=0 until a word arrives, and weight holds its last value.
REQ-021 After the bit with total_bit=N_BITS-1: go to DONE; DONE asserts load_done=1 for exactly one cycle, then returns to IDLE with busy=0.
REQ-022 weight and weight_en SHALL be registered outputs, aligned in the same cycle, with 1-cycle latency from word acceptance to the first bit.
REQ-023 s_ready SHALL be 0 in IDLE and DONE; s_data is never consumed outside a load.
REQ-024 Total weight_en=1 cycles per load SHALL equal N_BITS exactly; N_BITS/WORD_W words are consumed.

Reset
REQ-025 On rst=1, asynchronously force state=IDLE, shift register=0, counters=0, weight=0, weight_en=0, s_ready=0, busy=0, load_done=0.
REQ-026 rst mid-load SHALL abandon the load with no load_done pulse; the next start begins from bit 0.

Structure
REQ-027 The FSM state encoding, WORD_W and N_BITS defaults SHALL live in the shared BNN package used by the fc_* blocks.
REQ-028 One sub-module, piso_shift (parallel-in, serial-out, MSB first, load and shift enables), is natural; the FSM and counters stay in the top.

Verification
REQ-029 Scenario: start, s_valid held 1, words 0xFFFF0000, 0x0, 0xAAAAAAAA, 0x1, 0x80000000, 0x7FFFFFFF -> 192 contiguous weight_en cycles; first bits 1x16 then 0x16; load_done exactly 1 cycle after the last bit.
REQ-030 Scenario: s_valid dropped 5 cycles between words 2 and 3 -> weight_en low for 5+1 cycles; bit sequence unchanged; total weight_en count = 192.
REQ-031 Scenario: start pulsed again at bit 50 -> ignored; exactly 6 words consumed and one load_done.
REQ-032 Scenario: rst asserted at bit 100 -> outputs 0 immediately with no clock edge; no load_done; a new start reloads from word 0.
REQ-033 Scenario: end-to-end with fc_12 -> 192 weight bits driven into fc_12; then ivalid stimulus; fc_12 dout matches the golden model from the weight file.
REQ-034 Scenario: s_valid=1 while IDLE -> s_ready=0 and no word consumed.
